// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch path: default sizes and the fetch FSM state type.
package pc_pkg;

    localparam int PC_WIDTH_DEF    = 8;
    localparam int INSTR_WIDTH_DEF = 16;
    localparam int RESET_PC_DEF    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and single-outstanding instruction fetch over a req/ack port,
// holding the fetched instruction for decode until it is accepted or flushed by a branch.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int RESET_PC    = RESET_PC_DEF
) (
    input  logic                   Clk,
    input  logic                   Clear_n,
    output logic [PC_WIDTH-1:0]    PC,
    input  logic [PC_WIDTH-1:0]    Next_PC,
    input  logic                   Branch_Valid,
    input  logic [PC_WIDTH-1:0]    Branch_Target,
    input  logic                   Stall,
    output logic                   Mem_Req,
    output logic [PC_WIDTH-1:0]    Mem_Addr,
    input  logic                   Mem_Ack,
    input  logic [INSTR_WIDTH-1:0] Mem_Data,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic                   Instr_Valid,
    input  logic                   Instr_Ready
);

    fetch_state_t           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   br_pend_q, br_pend_d;
    logic [PC_WIDTH-1:0]    br_tgt_q, br_tgt_d;
    logic                   accept;

    assign accept = Instr_Ready & ~Stall;

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            pc_q      <= PC_WIDTH'(RESET_PC);
            instr_q   <= '0;
            br_pend_q <= 1'b0;
            br_tgt_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            br_pend_q <= br_pend_d;
            br_tgt_q  <= br_tgt_d;
        end
    end

    // A branch seen while a request is outstanding is remembered so the returning
    // data can be discarded; the request itself is never cut short.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        br_pend_d = br_pend_q;
        br_tgt_d  = br_tgt_q;
        case (state_q)
            IDLE: begin
                if (!Stall) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (Mem_Ack) begin
                    if (br_pend_q || Branch_Valid) begin
                        pc_d      = Branch_Valid ? Branch_Target : br_tgt_q;
                        br_pend_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        instr_d = Mem_Data;
                        state_d = HOLD;
                    end
                end else if (Branch_Valid) begin
                    br_pend_d = 1'b1;
                    br_tgt_d  = Branch_Target;
                end
            end
            HOLD: begin
                if (accept) begin
                    pc_d    = Branch_Valid ? Branch_Target : Next_PC;
                    state_d = FETCH;
                end else if (Branch_Valid) begin
                    pc_d    = Branch_Target;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        PC          = pc_q;
        Mem_Addr    = pc_q;
        Instr       = instr_q;
        Mem_Req     = (state_q == FETCH);
        Instr_Valid = (state_q == HOLD);
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios then random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_pc_fetch_unit;

    logic        Clk = 1'b0;
    logic        Clear_n = 1'b1;
    logic [7:0]  PC, Next_PC, Branch_Target, Mem_Addr;
    logic        Branch_Valid = 1'b0, Stall = 1'b1, Mem_Ack = 1'b0, Instr_Ready = 1'b0;
    logic        Mem_Req, Instr_Valid;
    logic [15:0] Mem_Data = 16'h0, Instr;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0]  mPc, mTgt;
    logic [15:0] mInstr;
    bit          mFetching, mHolding, mPend;

    always #5 Clk = ~Clk;

    // Stand-in for the external combinational incrementer.
    assign Next_PC = PC + 8'd1;

    pc_fetch_unit dut (
        .Clk(Clk), .Clear_n(Clear_n), .PC(PC), .Next_PC(Next_PC),
        .Branch_Valid(Branch_Valid), .Branch_Target(Branch_Target), .Stall(Stall),
        .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data),
        .Instr(Instr), .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready)
    );

    task automatic modelReset();
        mPc = 8'h00; mTgt = 8'h00; mInstr = 16'h0;
        mFetching = 0; mHolding = 0; mPend = 0;
    endtask

    task automatic modelStep();
        if (mFetching) begin
            if (Mem_Ack) begin
                if (mPend || Branch_Valid) mPc = Branch_Valid ? Branch_Target : mTgt;
                else begin
                    mInstr = Mem_Data;
                    mHolding = 1;
                end
                mPend = 0;
                mFetching = 0;
            end else if (Branch_Valid) begin
                mPend = 1;
                mTgt = Branch_Target;
            end
        end else if (mHolding) begin
            if (Instr_Ready && !Stall) begin
                mPc = Branch_Valid ? Branch_Target : mPc + 8'd1;
                mHolding = 0;
                mFetching = 1;
            end else if (Branch_Valid) begin
                mPc = Branch_Target;
                mHolding = 0;
                mFetching = 1;
            end
        end else if (!Stall) begin
            mFetching = 1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compareAll();
        checkOutput("pc", 32'(PC), 32'(mPc));
        checkOutput("mem_addr", 32'(Mem_Addr), 32'(mPc));
        checkOutput("mem_req", 32'(Mem_Req), 32'(mFetching));
        checkOutput("instr_valid", 32'(Instr_Valid), 32'(mHolding));
        checkOutput("instr", 32'(Instr), 32'(mInstr));
    endtask

    task automatic applyStimulus(input logic stall, input logic bv, input logic [7:0] bt,
                                 input logic rdy, input logic ack, input logic [15:0] data);
        Stall = stall; Branch_Valid = bv; Branch_Target = bt;
        Instr_Ready = rdy; Mem_Ack = ack; Mem_Data = data;
        @(posedge Clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic fetchOne(input logic [7:0] expAddr, input int delay, output logic [15:0] data);
        int n = 0;
        while (Mem_Req !== 1'b1 && n < 10) begin
            applyStimulus(0, 0, 8'h00, 0, 0, 16'(($urandom)));
            n++;
        end
        checkOutput("req_seen", 32'(Mem_Req), 32'd1);
        checkOutput("fetch_addr", 32'(Mem_Addr), 32'(expAddr));
        repeat (delay) applyStimulus(0, 0, 8'h00, 0, 0, 16'(($urandom)));
        data = 16'($urandom);
        applyStimulus(0, 0, 8'h00, 0, 1, data);
        checkOutput("instr_captured", 32'(Instr), 32'(data));
        checkOutput("valid_after_ack", 32'(Instr_Valid), 32'd1);
        checkOutput("req_low_in_hold", 32'(Mem_Req), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] held;
        Branch_Target = 8'h00;

        // Reset state and the basic in-order fetch stream.
        #1 Clear_n = 1'b0;
        #12;
        modelReset();
        checkOutput("reset_pc", 32'(PC), 32'd0);
        checkOutput("reset_req", 32'(Mem_Req), 32'd0);
        checkOutput("reset_valid", 32'(Instr_Valid), 32'd0);
        checkOutput("reset_instr", 32'(Instr), 32'd0);
        Clear_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            fetchOne(8'(a), 2, d);
            applyStimulus(0, 0, 8'h00, 1, 0, 16'h0);
            checkOutput("valid_one_cycle", 32'(Instr_Valid), 32'd0);
        end

        // PC wrap from all-ones.
        fetchOne(8'h04, 1, d);
        applyStimulus(0, 1, 8'hFF, 1, 0, 16'h0);
        fetchOne(8'hFF, 1, d);
        applyStimulus(0, 0, 8'h00, 1, 0, 16'h0);
        checkOutput("wrap_pc", 32'(PC), 32'h00);
        fetchOne(8'h00, 1, d);
        applyStimulus(0, 1, 8'h05, 1, 0, 16'h0);

        // Branch during an outstanding fetch discards the returning data.
        checkOutput("fetch_at_5", 32'(Mem_Addr), 32'h05);
        applyStimulus(0, 1, 8'h40, 0, 0, 16'h0);
        applyStimulus(0, 0, 8'h00, 0, 0, 16'h0);
        applyStimulus(0, 0, 8'h00, 0, 0, 16'h0);
        applyStimulus(0, 0, 8'h00, 0, 1, 16'hDEAD);
        checkOutput("flush_no_valid", 32'(Instr_Valid), 32'd0);
        checkOutput("flush_pc", 32'(PC), 32'h40);
        fetchOne(8'h40, 1, d);
        applyStimulus(0, 0, 8'h00, 1, 0, 16'h0);

        // Hold under back-pressure and stall.
        fetchOne(8'h41, 2, d);
        held = Instr;
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i == 1 || i == 2), 0, 8'h00, 0, 0, 16'h0);
            checkOutput("hold_instr", 32'(Instr), 32'(held));
            checkOutput("hold_pc", 32'(PC), 32'h41);
        end
        applyStimulus(1, 0, 8'h00, 1, 0, 16'h0);
        checkOutput("stall_blocks_accept", 32'(Instr_Valid), 32'd1);
        applyStimulus(0, 0, 8'h00, 1, 0, 16'h0);
        checkOutput("accept_pc", 32'(PC), 32'h42);

        // Branch flush while holding an unaccepted instruction.
        fetchOne(8'h42, 1, d);
        applyStimulus(0, 1, 8'h10, 0, 0, 16'h0);
        checkOutput("hold_flush_valid", 32'(Instr_Valid), 32'd0);
        checkOutput("hold_flush_addr", 32'(Mem_Addr), 32'h10);
        checkOutput("hold_flush_req", 32'(Mem_Req), 32'd1);

        // Asynchronous reset mid-fetch, then a late ack while idle.
        applyStimulus(0, 0, 8'h00, 0, 0, 16'h0);
        #2 Clear_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_req", 32'(Mem_Req), 32'd0);
        checkOutput("async_valid", 32'(Instr_Valid), 32'd0);
        checkOutput("async_pc", 32'(PC), 32'd0);
        #2 Clear_n = 1'b1;
        applyStimulus(1, 0, 8'h00, 0, 1, 16'hBEEF);
        checkOutput("late_ack_valid", 32'(Instr_Valid), 32'd0);
        checkOutput("late_ack_instr", 32'(Instr), 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 0, 16'h0);
        checkOutput("restart_addr", 32'(Mem_Addr), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(3) == 0), ($urandom_range(9) == 0), 8'($urandom),
                          ($urandom_range(4) < 3), ($urandom_range(9) < 4), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
